// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch sequencer: FSM encoding and
// default fetch stride / reset vector.
package fetch_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ISSUE     = 2'd1,
    WAIT_BUSY = 2'd2,
    WAIT_DONE = 2'd3
  } fetch_state_e;

  localparam int unsigned DEF_INSTR_BYTES  = 32'd4;
  localparam logic [31:0] DEF_RESET_VECTOR = 32'h0000_0000;

endpackage

// File: rtl/fetch_sequencer_if.sv
// Bundle of opcode-buffer, redirect and decode-side handshake signals.
// The sequencer is the master; the opcode buffer plus decode form the slave side.
interface fetch_sequencer_if #(
  parameter int ADDRESS_WIDTH = 32,
  parameter int WORD_WIDTH    = 32,
  parameter int DEPTH         = 4
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic [ADDRESS_WIDTH-1:0] ip;
  logic                     startLoading;
  logic                     loadBusy;
  logic [WORD_WIDTH-1:0]    opcode;
  logic                     redirect;
  logic [ADDRESS_WIDTH-1:0] redirectTarget;
  logic                     outValid;
  logic                     outReady;
  logic [WORD_WIDTH-1:0]    outOpcode;
  logic [ADDRESS_WIDTH-1:0] outAddress;
  logic [CW-1:0]            count;

  modport master (
    output ip, startLoading, outValid, outOpcode, outAddress, count,
    input  loadBusy, opcode, redirect, redirectTarget, outReady
  );

  modport slave (
    input  ip, startLoading, outValid, outOpcode, outAddress, count,
    output loadBusy, opcode, redirect, redirectTarget, outReady
  );

endinterface

// File: rtl/fetch_fifo.sv
// Synchronous FIFO holding {opcode, address} fetch entries.
// Flush has priority over push and pop.
module fetch_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  logic                   pop,
  input  logic                   flush,
  input  logic [WIDTH-1:0]       wdata,
  output logic [WIDTH-1:0]       rdata,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW-1:0]    wr_ptr_r;
  logic [AW-1:0]    rd_ptr_r;
  logic [AW:0]      count_r;
  logic             do_push_s;
  logic             do_pop_s;

  assign do_push_s = push && !full && !flush;
  assign do_pop_s  = pop && !empty && !flush;
  assign full      = (count_r == FULL_CNT);
  assign empty     = (count_r == (AW+1)'(0));
  assign count     = count_r;
  assign rdata     = mem_r[rd_ptr_r];

  // Entry storage; cleared on reset so the head reads zero before the first push
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= {WIDTH{1'b0}};
      end
    end else if (do_push_s) begin
      mem_r[wr_ptr_r] <= wdata;
    end
  end

  // Read/write pointers and occupancy
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_r <= AW'(0);
      rd_ptr_r <= AW'(0);
      count_r  <= (AW+1)'(0);
    end else if (flush) begin
      wr_ptr_r <= AW'(0);
      rd_ptr_r <= AW'(0);
      count_r  <= (AW+1)'(0);
    end else begin
      if (do_push_s) wr_ptr_r <= wr_ptr_r + AW'(1);
      if (do_pop_s)  rd_ptr_r <= rd_ptr_r + AW'(1);
      case ({do_push_s, do_pop_s})
        2'b10:   count_r <= count_r + (AW+1)'(1);
        2'b01:   count_r <= count_r - (AW+1)'(1);
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/fetch_sequencer.sv
// Sequential instruction fetch: one non-overlapped request at a time to the
// opcode buffer, tagged words queued for decode, redirects flush and discard.
module fetch_sequencer
  import fetch_pkg::*;
#(
  parameter int                     ADDRESS_WIDTH = 32,
  parameter int                     WORD_WIDTH    = 32,
  parameter int                     DEPTH         = 4,
  parameter int                     INSTR_BYTES   = DEF_INSTR_BYTES,
  parameter logic [ADDRESS_WIDTH-1:0] RESET_VECTOR = ADDRESS_WIDTH'(DEF_RESET_VECTOR)
) (
  input  logic               clk,
  input  logic               reset,
  fetch_sequencer_if.master  bus
);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam int DW = WORD_WIDTH + ADDRESS_WIDTH;

  fetch_state_e             state_r;
  fetch_state_e             state_next_s;
  logic [ADDRESS_WIDTH-1:0] ip_r;
  logic [ADDRESS_WIDTH-1:0] ip_next_s;
  logic                     discard_r;
  logic                     discard_next_s;
  logic                     push_s;
  logic                     pop_s;
  logic                     flush_s;
  logic                     full_s;
  logic                     empty_s;
  logic [DW-1:0]            head_s;
  logic [CW-1:0]            count_s;

  fetch_fifo #(.WIDTH(DW), .DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push_s),
    .pop   (pop_s),
    .flush (flush_s),
    .wdata ({bus.opcode, ip_r}),
    .rdata (head_s),
    .full  (full_s),
    .empty (empty_s),
    .count (count_s)
  );

  assign pop_s            = !empty_s && bus.outReady && !bus.redirect;
  assign bus.ip           = ip_r;
  assign bus.startLoading = (state_r == ISSUE);
  assign bus.outValid     = !empty_s;
  assign bus.outOpcode    = head_s[DW-1:ADDRESS_WIDTH];
  assign bus.outAddress   = head_s[ADDRESS_WIDTH-1:0];
  assign bus.count        = count_s;

  // FSM state, fetch pointer and discard flag
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r   <= IDLE;
      ip_r      <= RESET_VECTOR;
      discard_r <= 1'b0;
    end else begin
      state_r   <= state_next_s;
      ip_r      <= ip_next_s;
      discard_r <= discard_next_s;
    end
  end

  // Next-state, capture and redirect handling
  always_comb begin
    state_next_s   = state_r;
    ip_next_s      = ip_r;
    discard_next_s = discard_r;
    push_s         = 1'b0;
    flush_s        = 1'b0;
    // Issuing only when not full reserves a slot for the single in-flight word.
    case (state_r)
      IDLE: begin
        if (!full_s && !bus.loadBusy) state_next_s = ISSUE;
        else                          state_next_s = IDLE;
      end
      ISSUE: state_next_s = WAIT_BUSY;
      WAIT_BUSY: begin
        if (bus.loadBusy) state_next_s = WAIT_DONE;
        else              state_next_s = WAIT_BUSY;
      end
      WAIT_DONE: begin
        if (!bus.loadBusy) begin
          state_next_s = IDLE;
          if (discard_r) begin
            discard_next_s = 1'b0;
          end else begin
            push_s    = 1'b1;
            ip_next_s = ip_r + ADDRESS_WIDTH'(INSTR_BYTES);
          end
        end else begin
          state_next_s = WAIT_DONE;
        end
      end
      default: state_next_s = IDLE;
    endcase
    // A redirect outranks any capture; a request the buffer already took is marked for discard.
    if (bus.redirect) begin
      flush_s   = 1'b1;
      push_s    = 1'b0;
      ip_next_s = bus.redirectTarget;
      case (state_r)
        IDLE: begin
          state_next_s   = IDLE;
          discard_next_s = 1'b0;
        end
        ISSUE: begin
          state_next_s   = WAIT_BUSY;
          discard_next_s = 1'b1;
        end
        WAIT_BUSY, WAIT_DONE: begin
          state_next_s   = state_r;
          discard_next_s = 1'b1;
        end
        default: begin
          state_next_s   = IDLE;
          discard_next_s = 1'b0;
        end
      endcase
    end else begin
      flush_s = 1'b0;
    end
  end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Scoreboard bench for fetch_sequencer: an opcode buffer model answers each
// start pulse with 0xAABBCC00+n, and a monitor checks every popped head.
module tb_fetch_sequencer;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  fetch_sequencer_if #(.ADDRESS_WIDTH(32), .WORD_WIDTH(32), .DEPTH(4)) bus();

  fetch_sequencer #(
    .ADDRESS_WIDTH(32), .WORD_WIDTH(32), .DEPTH(4),
    .INSTR_BYTES(4), .RESET_VECTOR(32'h0000_0100)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int          total = 0;
  int          bad   = 0;
  logic [63:0] exp_q[$];
  int          n_done = 0;
  int          n_issued = 0;
  int          lat = 0;
  logic [31:0] last_issue_ip = 32'h0;
  logic        prev_start = 1'b0;
  logic [63:0] got;
  logic [63:0] want;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, expv);
    end
  endtask

  task automatic expect_word(input logic [31:0] addr, input int k);
    exp_q.push_back({addr, 32'hAABB_CC00 + 32'(k)});
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_count(input int v, input string name);
    int i = 0;
    while (64'(bus.count) != 64'(v) && i < 300) begin
      tick();
      i++;
    end
    if (64'(bus.count) != 64'(v)) begin
      total++;
      bad++;
      $display("FAIL %s: timeout, count=%0d required %0d", name, bus.count, v);
    end
  endtask

  task automatic wait_busy(input logic lvl, input string name);
    int i = 0;
    while (bus.loadBusy !== lvl && i < 300) begin
      tick();
      i++;
    end
    if (bus.loadBusy !== lvl) begin
      total++;
      bad++;
      $display("FAIL %s: timeout, loadBusy=%b required %b", name, bus.loadBusy, lvl);
    end
  endtask

  // Opcode buffer model: busy three cycles after a start, word valid as busy falls
  initial begin
    bus.loadBusy = 1'b0;
    bus.opcode   = 32'h0;
    forever begin
      @(posedge clk);
      #1;
      if (!reset) begin
        bus.loadBusy = 1'b0;
        lat = 0;
      end else if (bus.startLoading && !bus.loadBusy) begin
        bus.loadBusy  = 1'b1;
        lat           = 2;
        n_issued++;
        last_issue_ip = bus.ip;
      end else if (bus.loadBusy) begin
        if (lat == 0) begin
          bus.loadBusy = 1'b0;
          bus.opcode   = 32'hAABB_CC00 + 32'(n_done);
          n_done++;
        end else begin
          lat--;
        end
      end
    end
  end

  // Monitor: pops and compares the scoreboard on each accepted head
  always @(negedge clk) begin
    if (reset === 1'b1) begin
      if (bus.outValid && bus.outReady && !bus.redirect) begin
        total++;
        got = {bus.outAddress, bus.outOpcode};
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL pop: got %h expected no entry", got);
        end else begin
          want = exp_q.pop_front();
          if (got !== want) begin
            bad++;
            $display("FAIL pop: got addr/op %h expected %h", got, want);
          end
        end
      end
      if (bus.startLoading) begin
        total++;
        if (prev_start) begin
          bad++;
          $display("FAIL start_pulse: got 2-cycle startLoading expected 1 cycle");
        end
      end
      if (bus.count > 3'd4) begin
        total++;
        bad++;
        $display("FAIL overflow: got count %0d expected <= 4", bus.count);
      end
      prev_start = bus.startLoading;
    end else begin
      prev_start = 1'b0;
    end
  end

  initial begin
    reset              = 1'b1;
    bus.redirect       = 1'b0;
    bus.redirectTarget = 32'h0;
    bus.outReady       = 1'b0;
    #1 reset = 1'b0;
    #2;
    check("rst_valid",   64'(bus.outValid),     64'd0);
    check("rst_count",   64'(bus.count),        64'd0);
    check("rst_start",   64'(bus.startLoading), 64'd0);
    check("rst_ip",      64'(bus.ip),           64'h100);
    check("rst_opcode",  64'(bus.outOpcode),    64'd0);
    check("rst_address", 64'(bus.outAddress),   64'd0);

    // Fill with decode stalled
    for (int k = 0; k < 4; k++) expect_word(32'h100 + 32'(4 * k), k);
    tick();
    tick();
    reset = 1'b1;
    wait_count(4, "fill");
    repeat (20) tick();
    check("fill_count",  64'(bus.count), 64'd4);
    check("fill_issued", 64'(n_issued),  64'd4);
    bus.outReady = 1'b1;
    tick();
    bus.outReady = 1'b0;
    check("pop_count", 64'(bus.count), 64'd3);
    expect_word(32'h110, 4);
    wait_count(4, "refill");
    check("refill_issued", 64'(n_issued), 64'd5);

    // Redirect during WAIT_DONE with two entries queued
    bus.outReady = 1'b1;
    tick();
    tick();
    bus.outReady = 1'b0;
    wait_busy(1'b1, "rd1_busy");
    tick();
    tick();
    bus.redirect       = 1'b1;
    bus.redirectTarget = 32'h2000;
    tick();
    bus.redirect = 1'b0;
    exp_q.delete();
    check("rd1_count", 64'(bus.count),    64'd0);
    check("rd1_valid", 64'(bus.outValid), 64'd0);
    check("rd1_ip",    64'(bus.ip),       64'h2000);
    expect_word(32'h2000, 6);
    wait_count(1, "rd1_refill");
    bus.outReady = 1'b1;
    tick();
    bus.outReady = 1'b0;

    // Redirect together with a pop and a completing fetch
    expect_word(32'h2004, 7);
    wait_count(1, "rd2_fill");
    wait_busy(1'b1, "rd2_busy");
    wait_busy(1'b0, "rd2_done");
    bus.redirect       = 1'b1;
    bus.redirectTarget = 32'h3000;
    bus.outReady       = 1'b1;
    tick();
    bus.redirect = 1'b0;
    bus.outReady = 1'b0;
    exp_q.delete();
    check("rd2_count", 64'(bus.count),    64'd0);
    check("rd2_valid", 64'(bus.outValid), 64'd0);
    check("rd2_ip",    64'(bus.ip),       64'h3000);

    // Address wrap at the top of the space
    expect_word(32'h3000, 9);
    wait_count(1, "wrap_fill");
    wait_busy(1'b1, "wrap_busy");
    tick();
    tick();
    bus.redirect       = 1'b1;
    bus.redirectTarget = 32'hFFFF_FFFC;
    tick();
    bus.redirect = 1'b0;
    exp_q.delete();
    check("wrap_redirect_ip", 64'(bus.ip), 64'hFFFF_FFFC);
    expect_word(32'hFFFF_FFFC, 11);
    expect_word(32'h0000_0000, 12);
    wait_count(2, "wrap_count");
    check("wrap_ip", 64'(bus.ip), 64'h4);
    bus.outReady = 1'b1;
    tick();
    tick();
    bus.outReady = 1'b0;
    check("wrap_issue_ip", 64'(last_issue_ip), 64'h4);

    // Asynchronous reset while the fetch sits in WAIT_DONE
    wait_busy(1'b0, "arst_done");
    reset = 1'b0;
    #1;
    exp_q.delete();
    check("arst_valid",   64'(bus.outValid),     64'd0);
    check("arst_count",   64'(bus.count),        64'd0);
    check("arst_start",   64'(bus.startLoading), 64'd0);
    check("arst_ip",      64'(bus.ip),           64'h100);
    check("arst_opcode",  64'(bus.outOpcode),    64'd0);
    check("arst_address", 64'(bus.outAddress),   64'd0);
    tick();
    tick();
    reset = 1'b1;
    expect_word(32'h100, 14);
    wait_count(1, "post_rst_fill");
    bus.outReady = 1'b1;
    tick();
    bus.outReady = 1'b0;
    repeat (3) tick();
    check("drained", 64'(exp_q.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
